// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-access engine: op encodings, FSM states and op classifiers.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MOP_LDW = 3'd0,
    MOP_LDB = 3'd1,
    MOP_STW = 3'd2,
    MOP_STB = 3'd3,
    MOP_LDI = 3'd4,
    MOP_STI = 3'd5
  } lc3b_memop;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_PTR    = 2'd2,
    S_DONE   = 2'd3
  } mau_state_t;

  // Indirect ops also move full words, so they share the alignment rule.
  function automatic logic is_word_op(input lc3b_memop op);
    case (op)
      MOP_LDB, MOP_STB: is_word_op = 1'b0;
      default:          is_word_op = 1'b1;
    endcase
  endfunction

  function automatic logic is_store(input lc3b_memop op);
    case (op)
      MOP_STW, MOP_STB, MOP_STI: is_store = 1'b1;
      default:                   is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_indirect(input lc3b_memop op);
    case (op)
      MOP_LDI, MOP_STI: is_indirect = 1'b1;
      default:          is_indirect = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane helper: one-hot lane enable, lane byte extract with zero-extend, byte replication.
module mem_lane_align #(
  parameter int WIDTH = 16
) (
  input  logic [$clog2(WIDTH/8)-1:0] lane_i,
  input  logic [7:0]                 wbyte_i,
  input  logic [WIDTH-1:0]           rdata_i,
  output logic [WIDTH/8-1:0]         be_onehot_o,
  output logic [WIDTH-1:0]           byte_zext_o,
  output logic [WIDTH-1:0]           wdata_rep_o
);
  localparam int LANES = WIDTH / 8;
  localparam int LB    = $clog2(LANES);

  logic [LB+2:0] bit_base_s;

  assign bit_base_s  = {lane_i, 3'b000};
  assign wdata_rep_o = {LANES{wbyte_i}};

  // Lane decode and byte pick for the selected lane.
  always_comb begin
    be_onehot_o          = '0;
    be_onehot_o[lane_i]  = 1'b1;
    byte_zext_o          = '0;
    byte_zext_o[7:0]     = rdata_i[bit_base_s +: 8];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access engine: word/byte loads and stores plus indirect (pointer-then-word) accesses
// over a req/resp port, with misalignment and response-timeout error reporting.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  lc3b_memop             op_i,
  input  logic [WIDTH-1:0]      addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [WIDTH/8-1:0]    mem_byte_enable_o,
  output logic [WIDTH-1:0]      mem_address_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_resp_i
);
  localparam int LANES = WIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT);

  mau_state_t       state_q;
  lc3b_memop        op_q;
  logic [LB-1:0]    lane_q;
  logic [WIDTH-1:0] wdata_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, err_q, mem_read_q, mem_write_q;
  logic [WIDTH-1:0] rdata_q, maddr_q, mwdata_q;
  logic [LANES-1:0] be_q;

  logic [LB-1:0]    lane_s;
  logic [LANES-1:0] be_onehot_s;
  logic [WIDTH-1:0] byte_zext_s, wdata_rep_s;
  logic             addr_mis_s, ptr_mis_s, timeout_hit_s;

  // While idle the incoming address picks the lane; afterwards the latched lane does.
  assign lane_s        = (state_q == S_IDLE) ? addr_i[LB-1:0] : lane_q;
  assign addr_mis_s    = |addr_i[LB-1:0];
  assign ptr_mis_s     = |mem_rdata_i[LB-1:0];
  assign timeout_hit_s = (TIMEOUT > 0) && !mem_resp_i &&
                         (({1'b0, cnt_q} + {{CW{1'b0}}, 1'b1}) == TO_LIM);

  mem_lane_align #(.WIDTH(WIDTH)) u_align (
    .lane_i      (lane_s),
    .wbyte_i     (wdata_i[7:0]),
    .rdata_i     (mem_rdata_i),
    .be_onehot_o (be_onehot_s),
    .byte_zext_o (byte_zext_s),
    .wdata_rep_o (wdata_rep_s)
  );

  // Control FSM with all outputs and request signals registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= MOP_LDW;
      lane_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      be_q        <= '0;
      maddr_q     <= '0;
      mwdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q    <= op_i;
            lane_q  <= addr_i[LB-1:0];
            wdata_q <= wdata_i;
            maddr_q <= addr_i;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (is_word_op(op_i) && addr_mis_s) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (is_indirect(op_i)) begin
              mem_read_q <= 1'b1;
              be_q       <= '1;
              state_q    <= S_PTR;
            end else begin
              mem_read_q  <= !is_store(op_i);
              mem_write_q <= is_store(op_i);
              be_q        <= is_word_op(op_i) ? {LANES{1'b1}} : be_onehot_s;
              mwdata_q    <= (op_i == MOP_STB) ? wdata_rep_s : wdata_i;
              state_q     <= S_ACCESS;
            end
          end
        end
        S_PTR: begin
          if (mem_resp_i) begin
            if (ptr_mis_s) begin
              mem_read_q <= 1'b0;
              err_q      <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              maddr_q <= mem_rdata_i;
              cnt_q   <= '0;
              op_q    <= (op_q == MOP_STI) ? MOP_STW : MOP_LDW;
              state_q <= S_ACCESS;
              if (op_q == MOP_STI) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b1;
                mwdata_q    <= wdata_q;
              end
            end
          end else if (timeout_hit_s) begin
            mem_read_q <= 1'b0;
            err_q      <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_ACCESS: begin
          if (mem_resp_i) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
            if (op_q == MOP_LDB) begin
              rdata_q <= byte_zext_s;
            end else if (op_q == MOP_LDW) begin
              rdata_q <= mem_rdata_i;
            end
          end else if (timeout_hit_s) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            err_q       <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          // Early error exits arrive with done low and raise it here for one cycle.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign rdata_o           = rdata_q;
  assign mem_read_o        = mem_read_q;
  assign mem_write_o       = mem_write_q;
  assign mem_byte_enable_o = be_q;
  assign mem_address_o     = maddr_q;
  assign mem_wdata_o       = mwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a wait-state memory responder and request monitor.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  lc3b_memop   op = MOP_LDW;
  logic [15:0] addr = 16'h0, wdata = 16'h0;
  logic        busy, done, err, mem_read, mem_write;
  logic [15:0] rdata, mem_address, mem_wdata;
  logic [1:0]  mem_be;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_resp = 1'b0;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [logic [15:0]];
  int          wait_cfg = 0;
  int          wcnt = 0;
  bit          mem_on = 1'b1;

  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [15:0] rd_addrs [$];
  logic        prev_rd = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [1:0]  last_be = 2'b00;
  logic [15:0] last_wd = 16'h0, last_wa = 16'h0;

  mem_access_unit #(.WIDTH(16), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .err_o(err), .rdata_o(rdata),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_byte_enable_o(mem_be),
    .mem_address_o(mem_address), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
  );

  always #5 clk = ~clk;

  // Memory responder: answers after wait_cfg idle cycles of a pending request
  always @(negedge clk) begin
    if ((mem_read || mem_write) && mem_on) begin
      if (wcnt == wait_cfg) begin
        mem_resp  = 1'b1;
        mem_rdata = mem.exists(mem_address) ? mem[mem_address] : 16'h0;
        wcnt      = 0;
      end else begin
        mem_resp = 1'b0;
        wcnt++;
      end
    end else begin
      mem_resp = 1'b0;
      wcnt     = 0;
    end
  end

  // Request monitor
  always @(negedge clk) begin
    if (mem_read) begin
      if (!prev_rd || mem_address != prev_addr) rd_addrs.push_back(mem_address);
      rd_cnt++;
    end
    if (mem_write) begin
      wr_cnt++;
      last_be = mem_be;
      last_wd = mem_wdata;
      last_wa = mem_address;
    end
    if (mem_read && mem_write) both_cnt++;
    prev_rd   = mem_read;
    prev_addr = mem_address;
  end

  task automatic run_op(input lc3b_memop o, input logic [15:0] a, input logic [15:0] d,
                        output int cyc);
    rd_cnt = 0;
    wr_cnt = 0;
    rd_addrs.delete();
    @(posedge clk); #1;
    op = o; addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
    end
    total++;
    if (cyc == 0) begin
      bad++;
      $display("FAIL op_timeout_bound: done never seen within 20 cycles (op=%0d addr=%h)", o, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, err, mem_read, mem_write} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {busy, done, err, mem_read, mem_write});
    end
    total++;
    if ({rdata, mem_address, mem_wdata, mem_be} !== 50'h0) begin
      bad++; $display("FAIL reset_data: got %h %h %h %b want zeros", rdata, mem_address, mem_wdata, mem_be);
    end
  endtask

  task automatic test_ldw();
    int cyc;
    mem[16'h1000] = 16'hBEEF; wait_cfg = 0;
    run_op(MOP_LDW, 16'h1000, 16'h0, cyc);
    total++;
    if (cyc !== 2) begin bad++; $display("FAIL ldw_latency: got %0d want 2", cyc); end
    total++;
    if (rdata !== 16'hBEEF || err !== 1'b0) begin
      bad++; $display("FAIL ldw_data: got rdata=%h err=%b want BEEF 0", rdata, err);
    end
    total++;
    if (rd_cnt !== 1 || wr_cnt !== 0) begin
      bad++; $display("FAIL ldw_req: got rd=%0d wr=%0d want 1 0", rd_cnt, wr_cnt);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL ldw_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_stb();
    int cyc;
    wait_cfg = 3;
    run_op(MOP_STB, 16'h2001, 16'h12A5, cyc);
    total++;
    if (cyc !== 5 || wr_cnt !== 4 || rd_cnt !== 0) begin
      bad++; $display("FAIL stb_timing: got done@%0d wr=%0d rd=%0d want 5 4 0", cyc, wr_cnt, rd_cnt);
    end
    total++;
    if (last_be !== 2'b10 || last_wd !== 16'hA5A5 || last_wa !== 16'h2001) begin
      bad++; $display("FAIL stb_bus: got be=%b wd=%h wa=%h want 10 A5A5 2001", last_be, last_wd, last_wa);
    end
    wait_cfg = 0;
  endtask

  task automatic test_ldi();
    int cyc;
    mem[16'h4000] = 16'h5000; mem[16'h5000] = 16'h1234; wait_cfg = 0;
    run_op(MOP_LDI, 16'h4000, 16'h0, cyc);
    total++;
    if (cyc !== 3 || rdata !== 16'h1234 || err !== 1'b0) begin
      bad++; $display("FAIL ldi_data: got done@%0d rdata=%h err=%b want 3 1234 0", cyc, rdata, err);
    end
    total++;
    if (rd_addrs.size() != 2 || rd_addrs[0] !== 16'h4000 || rd_addrs[1] !== 16'h5000) begin
      bad++; $display("FAIL ldi_phases: got n=%0d first=%h want 2 4000,5000", rd_addrs.size(),
                      (rd_addrs.size() > 0) ? rd_addrs[0] : 16'hxxxx);
    end
  endtask

  task automatic test_misaligned();
    int cyc;
    run_op(MOP_LDW, 16'h0101, 16'h0, cyc);
    total++;
    if (cyc !== 2 || err !== 1'b1 || rd_cnt !== 0 || wr_cnt !== 0) begin
      bad++; $display("FAIL mis_ldw: got done@%0d err=%b rd=%0d wr=%0d want 2 1 0 0", cyc, err, rd_cnt, wr_cnt);
    end
    total++;
    if (rdata !== 16'h1234) begin bad++; $display("FAIL mis_ldw_rdata: got %h want 1234", rdata); end
    mem[16'h7000] = 16'h6001;
    run_op(MOP_STI, 16'h7000, 16'h5555, cyc);
    total++;
    if (cyc !== 2 || err !== 1'b1 || rd_cnt !== 1 || wr_cnt !== 0) begin
      bad++; $display("FAIL mis_sti_ptr: got done@%0d err=%b rd=%0d wr=%0d want 2 1 1 0", cyc, err, rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_ldb();
    int cyc;
    mem[16'h3003] = 16'h80FF; mem[16'h3002] = 16'h80FF;
    run_op(MOP_LDB, 16'h3003, 16'h0, cyc);
    total++;
    if (rdata !== 16'h0080 || err !== 1'b0 || cyc !== 2) begin
      bad++; $display("FAIL ldb_hi: got rdata=%h err=%b done@%0d want 0080 0 2", rdata, err, cyc);
    end
    run_op(MOP_LDB, 16'h3002, 16'h0, cyc);
    total++;
    if (rdata !== 16'h00FF) begin bad++; $display("FAIL ldb_lo: got %h want 00FF", rdata); end
  endtask

  task automatic test_timeout();
    int cyc;
    mem_on = 1'b0;
    run_op(MOP_LDW, 16'h1000, 16'h0, cyc);
    total++;
    if (cyc !== 5 || rd_cnt !== 4 || err !== 1'b1) begin
      bad++; $display("FAIL timeout: got done@%0d rd=%0d err=%b want 5 4 1", cyc, rd_cnt, err);
    end
    total++;
    if (rdata !== 16'h00FF) begin bad++; $display("FAIL timeout_rdata: got %h want 00FF", rdata); end
  endtask

  task automatic test_rst_mid();
    int seen = 0;
    mem_on = 1'b0;
    @(posedge clk); #1;
    op = MOP_LDW; addr = 16'h1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, mem_read, mem_write, done, err} !== 5'b0 || rdata !== 16'h0 || mem_address !== 16'h0) begin
      bad++; $display("FAIL rst_mid: got busy=%b rd=%b wr=%b done=%b err=%b rdata=%h addr=%h want zeros",
                      busy, mem_read, mem_write, done, err, rdata, mem_address);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rst_no_done: got %0d pulses want 0", seen); end
    mem_on = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ldw();
    test_stb();
    test_ldi();
    test_misaligned();
    test_ldb();
    test_timeout();
    test_rst_mid();
    total++;
    if (both_cnt !== 0) begin bad++; $display("FAIL rd_wr_exclusive: got %0d overlaps want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
